// File: rtl/vend_pkg.sv
// Shared encodings for the vending transaction controller: FSM states,
// coin and selection codes, and one-hot dispenser item codes.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_VEND,
    ST_CHANGE
  } state_e;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;
  localparam logic [1:0] COIN_20   = 2'b11;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_A    = 2'b01;
  localparam logic [1:0] SEL_B    = 2'b10;
  localparam logic [1:0] SEL_C    = 2'b11;

  localparam logic [2:0] ITEM_NONE = 3'b000;
  localparam logic [2:0] ITEM_A    = 3'b001;
  localparam logic [2:0] ITEM_B    = 3'b010;
  localparam logic [2:0] ITEM_C    = 3'b100;

  function automatic logic [4:0] coin_value(input logic [1:0] code);
    logic [4:0] v;
    case (code)
      COIN_5:  v = 5'd5;
      COIN_10: v = 5'd10;
      COIN_20: v = 5'd20;
      default: v = 5'd0;
    endcase
    return v;
  endfunction

  function automatic logic [2:0] sel_to_item(input logic [1:0] code);
    logic [2:0] it;
    case (code)
      SEL_A:   it = ITEM_A;
      SEL_B:   it = ITEM_B;
      SEL_C:   it = ITEM_C;
      default: it = ITEM_NONE;
    endcase
    return it;
  endfunction

endpackage

// File: rtl/vend_ack_timer.sv
// Down-counter guarding the dispenser handshake; expired_o rises once the
// loaded window has fully elapsed without a clear.
module vend_ack_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic load_i,
  input  logic clear_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          active_q, active_d;

  // Loaded with TIMEOUT-1 so that the final in-window cycle sees zero.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (clear_i) begin
      cnt_d    = '0;
      active_d = 1'b0;
    end else if (load_i) begin
      cnt_d    = CW'(TIMEOUT - 1);
      active_d = 1'b1;
    end else if (active_q && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  assign expired_o = active_q && (cnt_q == '0);

endmodule

// File: rtl/vend_controller.sv
// Vending transaction controller: coin credit, price check, dispenser
// req/ack handshake with timeout, and change return as 5-unit pulses.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned PRICE_A     = 15,
  parameter int unsigned PRICE_B     = 25,
  parameter int unsigned PRICE_C     = 35,
  parameter int unsigned MAX_CREDIT  = 95,
  parameter int unsigned CREDIT_W    = 7,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic [1:0]          sel,
  input  logic                sel_valid,
  input  logic                cancel,
  input  logic                disp_ack,
  output logic                disp_req,
  output logic [2:0]          disp_item,
  output logic                change_pulse,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                insufficient,
  output logic                timeout_err,
  output logic                busy
);

  typedef logic [CREDIT_W-1:0] cred_t;
  typedef logic [CREDIT_W:0]   wide_t;

  localparam cred_t STEP = cred_t'(5);

  function automatic cred_t price_of(input logic [1:0] code);
    cred_t p;
    case (code)
      SEL_A:   p = cred_t'(PRICE_A);
      SEL_B:   p = cred_t'(PRICE_B);
      SEL_C:   p = cred_t'(PRICE_C);
      default: p = '0;
    endcase
    return p;
  endfunction

  state_e     state_q, state_d;
  cred_t      credit_q, credit_d;
  cred_t      price_q, price_d;
  logic [2:0] item_q, item_d;
  logic       req_q, req_d;
  logic       pulse_q, pulse_d;
  logic       rej_q, rej_d;
  logic       ins_q, ins_d;
  logic       tmo_q, tmo_d;
  logic       busy_q, busy_d;

  logic       tmr_load, tmr_clear, tmr_expired;
  wide_t      coin_sum;
  cred_t      sel_price;
  logic       coin_present;

  vend_ack_timer #(
    .TIMEOUT (ACK_TIMEOUT)
  ) u_ack_timer (
    .clk_i     (clk),
    .rst_ni    (reset),
    .load_i    (tmr_load),
    .clear_i   (tmr_clear),
    .expired_o (tmr_expired)
  );

  // One bit wider than the credit register so the overflow check cannot wrap.
  assign coin_sum     = {1'b0, credit_q} + wide_t'(coin_value(coin));
  assign sel_price    = price_of(sel);
  assign coin_present = (coin != COIN_NONE);

  always_comb begin
    state_d   = state_q;
    credit_d  = credit_q;
    price_d   = price_q;
    item_d    = item_q;
    req_d     = req_q;
    pulse_d   = 1'b0;
    rej_d     = 1'b0;
    ins_d     = 1'b0;
    tmo_d     = 1'b0;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;

    case (state_q)
      ST_IDLE, ST_COLLECT: begin
        if (cancel) begin
          rej_d   = coin_present;
          state_d = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
        end else if (sel_valid && (sel != SEL_NONE)) begin
          rej_d = coin_present;
          if (credit_q >= sel_price) begin
            credit_d = credit_q - sel_price;
            price_d  = sel_price;
            item_d   = sel_to_item(sel);
            req_d    = 1'b1;
            tmr_load = 1'b1;
            state_d  = ST_VEND;
          end else begin
            ins_d = 1'b1;
          end
        end else if (coin_present) begin
          if (coin_sum > wide_t'(MAX_CREDIT)) begin
            rej_d = 1'b1;
          end else begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = ST_COLLECT;
          end
        end
      end

      ST_VEND: begin
        rej_d = coin_present;
        if (disp_ack) begin
          req_d     = 1'b0;
          item_d    = ITEM_NONE;
          tmr_clear = 1'b1;
          state_d   = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
        end else if (tmr_expired) begin
          req_d     = 1'b0;
          item_d    = ITEM_NONE;
          credit_d  = credit_q + price_q;
          tmo_d     = 1'b1;
          tmr_clear = 1'b1;
          state_d   = ST_CHANGE;
        end
      end

      ST_CHANGE: begin
        rej_d = coin_present;
        // Leave only after a low pulse cycle so change_pulse always ends low.
        if (pulse_q || (credit_q == '0)) begin
          if (credit_q == '0) state_d = ST_IDLE;
        end else begin
          pulse_d  = 1'b1;
          credit_d = credit_q - STEP;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      credit_q <= '0;
      price_q  <= '0;
      item_q   <= ITEM_NONE;
      req_q    <= 1'b0;
      pulse_q  <= 1'b0;
      rej_q    <= 1'b0;
      ins_q    <= 1'b0;
      tmo_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      price_q  <= price_d;
      item_q   <= item_d;
      req_q    <= req_d;
      pulse_q  <= pulse_d;
      rej_q    <= rej_d;
      ins_q    <= ins_d;
      tmo_q    <= tmo_d;
      busy_q   <= busy_d;
    end
  end

  assign disp_req     = req_q;
  assign disp_item    = item_q;
  assign change_pulse = pulse_q;
  assign credit       = credit_q;
  assign coin_reject  = rej_q;
  assign insufficient = ins_q;
  assign timeout_err  = tmo_q;
  assign busy         = busy_q;

endmodule
